kbd_input_merge: RTL
====================

Name: kbd_input_merge

Overview:
- Parametrised keyboard-source merger that replaces the fixed single-source keyboard select.
- Accepts ASCII bytes from NUM_CH independent sources (UART RX, PS/2, USB HID, ...) and arbitrates them round-robin into one FIFO.
- Normalises characters to Apple-1 keyboard form.
- Presents the FIFO head to the PIA keyboard register ($D010/$D011) as a data/ready pair that the CPU read acknowledges.

Parameters:
- NUM_CH, 3, number of source channels (1..8).
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..64.
- DROP_ON_FULL, 0: 0 = back-pressure sources via ch_ready; 1 = ch_ready held high, bytes arriving while full are dropped and flagged.
- UPPERCASE, 1: 1 = map 'a'..'z' to 'A'..'Z'; 0 = pass unchanged.

Ports:
- clk25  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ch_valid  input  NUM_CH  per-channel byte valid.
- ch_data  input  8*NUM_CH  per-channel ASCII; channel i occupies bits [8i+7:8i].
- ch_ready  output  NUM_CH  per-channel accept.
- ch_enable  input  NUM_CH  channel mask; a disabled channel is never granted.
- flush  input  1  synchronous FIFO clear.
- kbd_ack  input  1  one-cycle pulse on CPU read of keyboard data; pops the head.
- kbd_data  output  8  FIFO head, bit7 forced to 1 (Apple-1 convention).
- kbd_ready  output  1  FIFO non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- ovf_flags  output  NUM_CH  sticky per-channel drop flags; valid only when DROP_ON_FULL=1, else tied to 0.
- ovf_clear  input  1  clears ovf_flags.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; fifo_count=0; kbd_ready=0; kbd_data=8'h80; ovf_flags=0.
  - Round-robin pointer = channel 0.
  - ch_ready = 0 when DROP_ON_FULL=0; = all-ones when DROP_ON_FULL=1.
- Reset mid-transfer discards all FIFO contents and any pending grant.
- Character transform (combinational, before push):
  - Bit7 cleared.
  - If UPPERCASE=1 and the byte is 0x61..0x7A, subtract 0x20.
  - Byte 0x0A is converted to 0x0D.
  - Bytes 0x00 and 0x7F are discarded: no push, but the handshake still completes.
- Arbitration (one grant per cycle):
  - Candidates are the channels with ch_valid & ch_enable.
  - Search starts at rr_ptr and wraps modulo NUM_CH; the first candidate wins.
  - On a grant, rr_ptr <= winner+1, wrapping from NUM_CH-1 to 0.
  - No candidate: rr_ptr unchanged.
- Handshake, DROP_ON_FULL=0:
  - ch_ready[i] is combinationally high only for the winner, and only when the FIFO is not full or kbd_ack is high this cycle.
  - A transfer happens when ch_valid & ch_ready are both high.
  - Sources hold valid/data until they see ready.
- Handshake, DROP_ON_FULL=1:
  - Every byte from the winner is consumed.
  - If the FIFO is full and kbd_ack=0, the byte is dropped and ovf_flags[winner] <= 1.
  - Non-winning valid channels are not consumed that cycle and must hold.
- FIFO behaviour:
  - Circular buffer with rd/wr pointers of width $clog2(FIFO_DEPTH); pointers wrap naturally.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when full (pop frees a slot in the same cycle) and when empty only if a pop is not requested.
  - kbd_ack when empty is ignored: no pointer change, count stays 0.
  - Count never exceeds FIFO_DEPTH and never underflows.
- Output timing:
  - kbd_data and kbd_ready are registered from FIFO state.
  - A byte pushed in cycle N is visible at cycle N+1.
  - After kbd_ack in cycle N, the next entry (or kbd_ready=0) appears at N+1.
- Clear priority:
  - flush has priority over push and pop in the same cycle. FIFO is emptied and kbd_ready=0 next cycle.
  - rr_ptr and ovf_flags are not affected by flush.
  - ovf_clear has priority over a same-cycle set.

Decomposition:
- Package kbd_pkg holds:
  - ASCII constants ASC_CR=8'h0D, ASC_LF=8'h0A, ASC_DEL=8'h7F, ASC_A_LO=8'h61, ASC_Z_LO=8'h7A.
  - APPLE_KBD_BIT7 mask.
- Sub-module kbd_fifo: parametrised DEPTH/WIDTH synchronous FIFO with push, pop, flush, full, empty and count.
- The arbiter, transform and handshake logic stay in kbd_input_merge.

Test Plan:
- Reset, then a single byte 0x61 on ch0 -> next cycle kbd_ready=1, kbd_data=0xC1. Pulse kbd_ack -> kbd_ready=0 the following cycle.
- Ch0, ch1 and ch2 all valid continuously with distinct bytes 0x41/0x42/0x43, rr_ptr=0 -> FIFO order 0xC1,0xC2,0xC3,0xC1…; each channel granted every third cycle.
- DROP_ON_FULL=0, FIFO_DEPTH=8: push 8 bytes without ack -> fifo_count=8 and all ch_ready=0. Next byte is accepted only in the kbd_ack cycle; count stays 8.
- DROP_ON_FULL=1: fill to 8, then send 0x45 on ch1 -> byte dropped, ovf_flags=3'b010, FIFO unchanged. Pulse ovf_clear -> ovf_flags=0.
- Send 0x0A and 0x7F on ch2 -> only 0x8D is queued; fifo_count=1.
- Queue 5 bytes, assert flush and kbd_ack in the same cycle -> count=0 and kbd_ready=0 next cycle. ch_enable=3'b110 with ch0 valid -> ch0 is never granted.

Source files
------------

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared ASCII constants and types for the keyboard input merger
package kbd_pkg;

    localparam logic [7:0] ASC_NUL        = 8'h00;
    localparam logic [7:0] ASC_LF         = 8'h0A;
    localparam logic [7:0] ASC_CR         = 8'h0D;
    localparam logic [7:0] ASC_DEL        = 8'h7F;
    localparam logic [7:0] ASC_A_LO       = 8'h61;
    localparam logic [7:0] ASC_Z_LO       = 8'h7A;
    localparam logic [7:0] ASC_CASE_DIFF  = 8'h20;

    // The Apple-1 PIA keyboard register always reads with bit7 set.
    localparam logic [7:0] APPLE_KBD_BIT7 = 8'h80;

    // Result of character normalisation: keep=0 means the byte is swallowed.
    typedef struct packed {
        logic       keep;
        logic [7:0] ch;
    } kbd_xform_t;

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - synchronous circular FIFO with push/pop/flush and occupancy count
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    // Empty FIFO presents zero so the consumer sees a clean idle value.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state: flush wins; otherwise pop of an empty FIFO is ignored and
    // a push into a full FIFO only lands when a pop frees a slot this cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State register; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/kbd_input_merge.sv
// rtl/kbd_input_merge.sv - round-robin merge of keyboard sources into the Apple-1 keyboard register
module kbd_input_merge
    import kbd_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int FIFO_DEPTH   = 8,
    parameter int DROP_ON_FULL = 0,
    parameter int UPPERCASE    = 1
) (
    input  logic                          clk25,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             ch_valid,
    input  logic [8*NUM_CH-1:0]           ch_data,
    output logic [NUM_CH-1:0]             ch_ready,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic                          flush,
    input  logic                          kbd_ack,
    output logic [7:0]                    kbd_data,
    output logic                          kbd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [NUM_CH-1:0]             ovf_flags,
    input  logic                          ovf_clear
);

    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    logic [NUM_CH-1:0] cand;
    logic              win_found;
    logic [RR_W-1:0]   win_idx;
    logic [NUM_CH-1:0] win_onehot;
    logic [7:0]        win_byte;
    kbd_xform_t        xf;

    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_rdata;
    logic              space;
    logic              consume;
    logic              fifo_push;
    logic [NUM_CH-1:0] ovf_set;

    // Normalise a raw source byte to Apple-1 keyboard form.
    function automatic kbd_xform_t kbd_xform(input logic [7:0] raw);
        kbd_xform_t r;
        r.ch = raw & ~APPLE_KBD_BIT7;
        if ((UPPERCASE != 0) && (r.ch >= ASC_A_LO) && (r.ch <= ASC_Z_LO)) begin
            r.ch = r.ch - ASC_CASE_DIFF;
        end
        if (r.ch == ASC_LF) begin
            r.ch = ASC_CR;
        end
        r.keep = (r.ch != ASC_NUL) && (r.ch != ASC_DEL);
        return r;
    endfunction

    assign cand = ch_valid & ch_enable;

    // Round-robin search starting at rr_ptr; first enabled valid channel wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_CH;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = RR_W'(idx);
            end
        end
    end

    assign win_onehot = NUM_CH'(1) << win_idx;
    assign win_byte   = ch_data[8*win_idx +: 8];
    assign xf         = kbd_xform(win_byte);

    // A pop in the same cycle frees a slot, so ack counts as room even when full.
    assign space = ~fifo_full | kbd_ack;

    // Handshake, push and overflow decisions for the winning channel.
    always_comb begin
        ch_ready = '0;
        consume  = 1'b0;
        ovf_set  = '0;
        if (DROP_ON_FULL != 0) begin
            ch_ready = '1;
            consume  = win_found;
            if (win_found && !space && xf.keep) begin
                ovf_set = win_onehot;
            end
        end else begin
            consume = win_found & space;
            if (consume) begin
                ch_ready = win_onehot & {NUM_CH{rst_n}};
            end
        end
        fifo_push = consume & space & xf.keep;
    end

    // Next rr pointer and sticky overflow flags; clear beats a same-cycle set.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        ovf_d    = ovf_q | ovf_set;
        if (consume) begin
            rr_ptr_d = (win_idx == RR_W'(NUM_CH - 1)) ? '0 : win_idx + RR_W'(1);
        end
        if (ovf_clear) begin
            ovf_d = '0;
        end
    end

    // Arbiter and overflow state registers.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            ovf_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk25),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (xf.ch),
        .pop   (kbd_ack),
        .flush (flush),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign kbd_data  = fifo_rdata | APPLE_KBD_BIT7;
    assign kbd_ready = ~fifo_empty;
    assign ovf_flags = (DROP_ON_FULL != 0) ? ovf_q : '0;

endmodule
